// File: rtl/jr_fwd_pipe_pkg.sv
// Shared types and constants for the decode-stage jr forwarding path.
// Holds the forward-select encodings, the producer-latency codes and the pipeline entry layout.
package jr_fwd_pipe_pkg;

    localparam int JR_XLEN = 32;
    localparam int JR_RA   = 5;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    localparam logic [1:0] TNEW_JAL  = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    typedef struct packed {
        logic               valid;
        logic               wen;
        logic [JR_RA-1:0]   waddr;
        logic [1:0]         tnew;
        logic [JR_XLEN-1:0] value;
    } pipe_entry_t;

    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One pipeline entry register (E, M or W) carrying a producer's destination and result.
// Stages after E count down tnew and pick up the freshly produced value when it appears.
module fwd_stage_reg
    import jr_fwd_pipe_pkg::*;
#(
    parameter bit DEC = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_bubble,
    input  pipe_entry_t         i_entry,
    input  logic [JR_XLEN-1:0]  i_repl_value,
    output pipe_entry_t         o_entry
);

    pipe_entry_t w_next;
    pipe_entry_t r_entry;

    always_comb begin
        w_next = i_entry;
        if (DEC) begin
            w_next.tnew = sat_dec(i_entry.tnew);
            // A producer finishing in the previous stage hands over its result here.
            if (i_entry.tnew == TNEW_ALU) begin
                w_next.value = i_repl_value;
            end
        end
        if (i_bubble) begin
            w_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry <= '0;
        end else begin
            r_entry <= w_next;
        end
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/jr_fwd_pipe.sv
// Producer side of the decode-stage jr forwarding path: E/M/W entry registers,
// youngest-first jr operand resolution, decode stall and the register-file write port.
module jr_fwd_pipe
    import jr_fwd_pipe_pkg::*;
#(
    parameter int XLEN = JR_XLEN,
    parameter int RA   = JR_RA
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            d_valid,
    input  logic            d_wen,
    input  logic [RA-1:0]   d_waddr,
    input  logic [1:0]      d_tnew,
    input  logic [XLEN-1:0] d_pc8,
    input  logic            d_jr,
    input  logic [RA-1:0]   d_rs,
    input  logic [XLEN-1:0] rf_rs_data,
    input  logic [XLEN-1:0] e_alu_result,
    input  logic [XLEN-1:0] m_mem_rdata,
    output logic            stall,
    output logic [1:0]      fwd_sel,
    output logic [XLEN-1:0] jr_target,
    output logic            w_wen,
    output logic [RA-1:0]   w_waddr,
    output logic [XLEN-1:0] w_wdata
);

    pipe_entry_t w_d_entry;
    pipe_entry_t w_e;
    pipe_entry_t w_m;
    pipe_entry_t w_w;
    logic        w_match_e;
    logic        w_match_m;
    logic        w_match_w;
    logic        w_jr_rs_live;

    always_comb begin
        w_d_entry.valid = 1'b1;
        w_d_entry.wen   = d_wen;
        w_d_entry.waddr = d_waddr;
        w_d_entry.tnew  = d_tnew;
        w_d_entry.value = d_pc8;
    end

    fwd_stage_reg #(.DEC(1'b0)) u_e_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_bubble     (stall | ~d_valid),
        .i_entry      (w_d_entry),
        .i_repl_value (d_pc8),
        .o_entry      (w_e)
    );

    fwd_stage_reg #(.DEC(1'b1)) u_m_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_bubble     (1'b0),
        .i_entry      (w_e),
        .i_repl_value (e_alu_result),
        .o_entry      (w_m)
    );

    fwd_stage_reg #(.DEC(1'b1)) u_w_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_bubble     (1'b0),
        .i_entry      (w_m),
        .i_repl_value (m_mem_rdata),
        .o_entry      (w_w)
    );

    assign w_jr_rs_live = d_jr & (d_rs != '0);
    assign w_match_e    = w_jr_rs_live & w_e.valid & w_e.wen & (w_e.waddr == d_rs);
    assign w_match_m    = w_jr_rs_live & w_m.valid & w_m.wen & (w_m.waddr == d_rs);
    assign w_match_w    = w_jr_rs_live & w_w.valid & w_w.wen & (w_w.waddr == d_rs);

    // The youngest matching producer decides; a not-ready younger one blocks older ready values.
    always_comb begin
        stall     = 1'b0;
        fwd_sel   = FWD_RF;
        jr_target = rf_rs_data;
        if (w_match_e) begin
            if (w_e.tnew == TNEW_JAL) begin
                fwd_sel   = FWD_E;
                jr_target = w_e.value;
            end else begin
                stall = 1'b1;
            end
        end else if (w_match_m) begin
            if (w_m.tnew == TNEW_JAL) begin
                fwd_sel   = FWD_M;
                jr_target = w_m.value;
            end else begin
                stall = 1'b1;
            end
        end else if (w_match_w) begin
            if (w_w.tnew == TNEW_JAL) begin
                fwd_sel   = FWD_W;
                jr_target = w_w.value;
            end else begin
                stall = 1'b1;
            end
        end
    end

    assign w_wen   = w_w.valid & w_w.wen & (w_w.waddr != '0);
    assign w_waddr = w_w.waddr;
    assign w_wdata = w_w.value;

endmodule

// File: tb/tb_jr_fwd_pipe.sv
// Directed bench for jr_fwd_pipe: jal/ALU/load forwarding, $0 writer, priority blocking
// and asynchronous reset during a stall, all against hand-computed values.
module tb_jr_fwd_pipe;

    logic        clk;
    logic        rst_n;
    logic        d_valid;
    logic        d_wen;
    logic [4:0]  d_waddr;
    logic [1:0]  d_tnew;
    logic [31:0] d_pc8;
    logic        d_jr;
    logic [4:0]  d_rs;
    logic [31:0] rf_rs_data;
    logic [31:0] e_alu_result;
    logic [31:0] m_mem_rdata;
    logic        stall;
    logic [1:0]  fwd_sel;
    logic [31:0] jr_target;
    logic        w_wen;
    logic [4:0]  w_waddr;
    logic [31:0] w_wdata;

    int checks   = 0;
    int failures = 0;

    jr_fwd_pipe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .d_valid      (d_valid),
        .d_wen        (d_wen),
        .d_waddr      (d_waddr),
        .d_tnew       (d_tnew),
        .d_pc8        (d_pc8),
        .d_jr         (d_jr),
        .d_rs         (d_rs),
        .rf_rs_data   (rf_rs_data),
        .e_alu_result (e_alu_result),
        .m_mem_rdata  (m_mem_rdata),
        .stall        (stall),
        .fwd_sel      (fwd_sel),
        .jr_target    (jr_target),
        .w_wen        (w_wen),
        .w_waddr      (w_waddr),
        .w_wdata      (w_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_prod(input logic [4:0] waddr, input logic [1:0] tnew, input logic [31:0] pc8);
        d_valid = 1'b1;
        d_wen   = 1'b1;
        d_waddr = waddr;
        d_tnew  = tnew;
        d_pc8   = pc8;
        d_jr    = 1'b0;
        d_rs    = 5'd0;
    endtask

    task automatic drive_jr(input logic [4:0] rs);
        d_valid = 1'b1;
        d_wen   = 1'b0;
        d_waddr = 5'd0;
        d_tnew  = 2'd0;
        d_pc8   = 32'h0000_0100;
        d_jr    = 1'b1;
        d_rs    = rs;
    endtask

    task automatic drive_idle();
        d_valid = 1'b0;
        d_wen   = 1'b0;
        d_waddr = 5'd0;
        d_tnew  = 2'd0;
        d_pc8   = 32'd0;
        d_jr    = 1'b0;
        d_rs    = 5'd0;
    endtask

    task automatic flush();
        drive_idle();
        repeat (3) tick();
    endtask

    initial begin
        rst_n        = 1'b0;
        rf_rs_data   = 32'hAAAA_0001;
        e_alu_result = 32'd0;
        m_mem_rdata  = 32'd0;
        drive_idle();
        d_jr = 1'b1;
        d_rs = 5'd3;
        #12;
        check_val("reset_stall", {31'd0, stall}, 32'd0);
        check_val("reset_fwd", {30'd0, fwd_sel}, 32'd0);
        check_val("reset_wen", {31'd0, w_wen}, 32'd0);
        check_val("reset_target", jr_target, 32'hAAAA_0001);
        rst_n = 1'b1;
        tick();

        // jal $31 then jr $31: forwarded from E with no stall
        drive_prod(5'd31, 2'd0, 32'h0040_0010);
        tick();
        drive_jr(5'd31);
        #1;
        check_val("jal_stall", {31'd0, stall}, 32'd0);
        check_val("jal_fwd", {30'd0, fwd_sel}, 32'd1);
        check_val("jal_target", jr_target, 32'h0040_0010);
        flush();

        // addu $8 then jr $8: one stall cycle, then forwarded from M
        drive_prod(5'd8, 2'd1, 32'h0000_0200);
        tick();
        drive_jr(5'd8);
        e_alu_result = 32'h0000_1234;
        #1;
        check_val("alu_stall0", {31'd0, stall}, 32'd1);
        check_val("alu_fwd0", {30'd0, fwd_sel}, 32'd0);
        tick();
        e_alu_result = 32'hDEAD_DEAD;
        #1;
        check_val("alu_stall1", {31'd0, stall}, 32'd0);
        check_val("alu_fwd1", {30'd0, fwd_sel}, 32'd2);
        check_val("alu_target", jr_target, 32'h0000_1234);
        flush();

        // lw $9 then jr $9: two stall cycles, then forwarded from W alongside the RF write
        drive_prod(5'd9, 2'd2, 32'h0000_0300);
        tick();
        drive_jr(5'd9);
        #1;
        check_val("ld_stall0", {31'd0, stall}, 32'd1);
        tick();
        m_mem_rdata = 32'hBEEF_0000;
        #1;
        check_val("ld_stall1", {31'd0, stall}, 32'd1);
        check_val("ld_fwd1", {30'd0, fwd_sel}, 32'd0);
        tick();
        m_mem_rdata = 32'h0000_0000;
        #1;
        check_val("ld_stall2", {31'd0, stall}, 32'd0);
        check_val("ld_fwd2", {30'd0, fwd_sel}, 32'd3);
        check_val("ld_target", jr_target, 32'hBEEF_0000);
        check_val("ld_wen", {31'd0, w_wen}, 32'd1);
        check_val("ld_waddr", {27'd0, w_waddr}, 32'd9);
        check_val("ld_wdata", w_wdata, 32'hBEEF_0000);
        flush();

        // addu $0 reaches M, jr $0: no forwarding, and no RF write from W
        drive_prod(5'd0, 2'd1, 32'h0000_0400);
        tick();
        drive_idle();
        e_alu_result = 32'h0000_0055;
        tick();
        drive_jr(5'd0);
        rf_rs_data = 32'h0000_1111;
        #1;
        check_val("r0_stall", {31'd0, stall}, 32'd0);
        check_val("r0_fwd", {30'd0, fwd_sel}, 32'd0);
        check_val("r0_target", jr_target, 32'h0000_1111);
        tick();
        #1;
        check_val("r0_wen", {31'd0, w_wen}, 32'd0);
        flush();

        // ori $5 (M, ready) behind lw $5 (E, not ready): the younger load blocks the ori value
        drive_prod(5'd5, 2'd1, 32'h0000_0500);
        tick();
        drive_prod(5'd5, 2'd2, 32'h0000_0504);
        e_alu_result = 32'h0000_0077;
        tick();
        drive_jr(5'd5);
        #1;
        check_val("blk_stall0", {31'd0, stall}, 32'd1);
        check_val("blk_fwd0", {30'd0, fwd_sel}, 32'd0);
        tick();
        m_mem_rdata = 32'hCAFE_0005;
        #1;
        check_val("blk_stall1", {31'd0, stall}, 32'd1);
        check_val("blk_fwd1", {30'd0, fwd_sel}, 32'd0);
        check_val("blk_wdata_ori", w_wdata, 32'h0000_0077);
        tick();
        #1;
        check_val("blk_stall2", {31'd0, stall}, 32'd0);
        check_val("blk_fwd2", {30'd0, fwd_sel}, 32'd3);
        check_val("blk_target", jr_target, 32'hCAFE_0005);
        flush();

        // asynchronous reset in the middle of a load stall
        drive_prod(5'd9, 2'd2, 32'h0000_0600);
        tick();
        drive_jr(5'd9);
        #1;
        check_val("rst_pre_stall", {31'd0, stall}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_stall", {31'd0, stall}, 32'd0);
        check_val("rst_mid_wen", {31'd0, w_wen}, 32'd0);
        #1;
        rst_n = 1'b1;
        drive_idle();
        tick();
        #1;
        check_val("rst_post_fwd", {30'd0, fwd_sel}, 32'd0);
        check_val("rst_post_stall", {31'd0, stall}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
